psec6_readout_sequencer: RTL and testbench

Readout controller on SPI_CLK for the PSEC6 channel digital blocks. On a START pulse it walks every enabled channel and, for each one, reads five 10-bit timestamp registers (CA..CE) and the trigger count. For each register it pulses that channel's INST_READOUT with SELECT_REG set, then deserializes the channel's CNT_SER bit stream into a tagged parallel word. Each word is delivered on a valid/ready interface to the chip-level SPI/FIFO.

---
 rtl/psec6_readout_sequencer_if.sv | 25 ++
 rtl/psec6_readout_sequencer.sv | 157 +++++++++++++++
 tb/tb_psec6_readout_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psec6_readout_sequencer_if.sv
// rtl/psec6_readout_sequencer_if.sv - start/mask, channel serial and word handshake bundle for the readout sequencer
interface psec6_readout_sequencer_if #(
  parameter int NUM_CH = 8
);
  logic              START;
  logic [NUM_CH-1:0] CH_MASK;
  logic [NUM_CH-1:0] CNT_SER;
  logic              DATA_READY;
  logic [NUM_CH-1:0] INST_READOUT;
  logic [2:0]        SELECT_REG;
  logic [15:0]       DATA_OUT;
  logic              DATA_VALID;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  START, CH_MASK, CNT_SER, DATA_READY,
    output INST_READOUT, SELECT_REG, DATA_OUT, DATA_VALID, BUSY, DONE
  );

  modport slave (
    output START, CH_MASK, CNT_SER, DATA_READY,
    input  INST_READOUT, SELECT_REG, DATA_OUT, DATA_VALID, BUSY, DONE
  );
endinterface

// File: rtl/psec6_readout_sequencer.sv
// rtl/psec6_readout_sequencer.sv - walks enabled channels, reads CA..CE and trigger_cnt, emits tagged words
module psec6_readout_sequencer #(
  parameter int NUM_CH = 8,
  parameter int WORD_W = 10
) (
  input  logic SPI_CLK,
  input  logic RST,
  psec6_readout_sequencer_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PRESENT, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [2:0]        ch_ptr_q, ch_ptr_d;
  logic [2:0]        reg_ptr_q, reg_ptr_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [NUM_CH-1:0] inst_q, inst_d;
  logic [2:0]        sel_q, sel_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_bit;
  logic              first_found, next_found;
  logic [2:0]        first_idx, next_idx;

  always_comb begin
    ser_bit     = 1'b0;
    first_found = 1'b0;
    first_idx   = 3'd0;
    next_found  = 1'b0;
    next_idx    = 3'd0;
    // Descending scans so the lowest qualifying channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_ptr_q == 3'(i)) ser_bit = bus.CNT_SER[i];
      if (bus.CH_MASK[i]) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if (mask_q[i] && (3'(i) > ch_ptr_q)) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_ptr_d  = ch_ptr_q;
    reg_ptr_d = reg_ptr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    inst_d    = '0;
    sel_d     = sel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mask_d    = bus.CH_MASK;
          reg_ptr_d = 3'd0;
          busy_d    = 1'b1;
          ch_ptr_d  = first_idx;
          state_d   = first_found ? S_LOAD : S_FINISH;
        end
      end
      S_LOAD: begin
        bit_cnt_d = 4'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        shift_d   = {shift_q[WORD_W-2:0], ser_bit};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(WORD_W - 1)) begin
          data_d  = {ch_ptr_q, reg_ptr_q, shift_d};
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.DATA_READY) begin
          valid_d = 1'b0;
          if (reg_ptr_q < 3'd5) begin
            reg_ptr_d = reg_ptr_q + 3'd1;
            state_d   = S_LOAD;
          end else if (next_found) begin
            ch_ptr_d  = next_idx;
            reg_ptr_d = 3'd0;
            state_d   = S_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Channel-facing and DONE outputs are registered off the next state so they line up with it.
    if (state_d == S_LOAD) begin
      sel_d = reg_ptr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_ptr_d == 3'(i)) inst_d[i] = 1'b1;
      end
    end
    if (state_d == S_FINISH) done_d = 1'b1;
  end

  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      ch_ptr_q  <= 3'd0;
      reg_ptr_q <= 3'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      inst_q    <= '0;
      sel_q     <= 3'd0;
      data_q    <= 16'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_ptr_q  <= ch_ptr_d;
      reg_ptr_q <= reg_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      inst_q    <= inst_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.INST_READOUT = inst_q;
  assign bus.SELECT_REG   = sel_q;
  assign bus.DATA_OUT     = data_q;
  assign bus.DATA_VALID   = valid_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;

endmodule

// File: tb/tb_psec6_readout_sequencer.sv
// tb/tb_psec6_readout_sequencer.sv - scoreboard bench for psec6_readout_sequencer with a behavioural channel model
module tb_psec6_readout_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psec6_readout_sequencer_if #(.NUM_CH(8)) bus ();

  psec6_readout_sequencer #(.NUM_CH(8), .WORD_W(10)) dut (
    .SPI_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic [9:0]  val [8][6];
  logic [9:0]  chsr [8];
  logic [15:0] sb [$];
  logic [7:0]  cur_mask = 8'h00;
  bit          bp_mode  = 1'b0;
  int          rx_count = 0;
  bit          pend     = 1'b0;
  logic [15:0] pend_data;

  // Channel model: load on the INST_READOUT edge, MSB first one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bus.INST_READOUT[i])
        chsr[i] <= (bus.SELECT_REG < 3'd6) ? val[i][bus.SELECT_REG] : 10'd0;
      else
        chsr[i] <= {chsr[i][8:0], 1'b0};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) bus.CNT_SER[i] = chsr[i][9];
  end

  always @(negedge clk) begin
    bus.DATA_READY = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst) begin
      if (pend) begin
        vectors++;
        if (bus.DATA_VALID !== 1'b1 || bus.DATA_OUT !== pend_data) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", bus.DATA_VALID, bus.DATA_OUT, pend_data);
        end
      end
      vectors++;
      if ($countones(bus.INST_READOUT) > 1 || (bus.INST_READOUT & ~cur_mask) != 8'h00) begin
        errors++;
        $display("FAIL inst_onehot_masked: inst=%b required onehot within mask %b", bus.INST_READOUT, cur_mask);
      end
      vectors++;
      if (bus.DATA_VALID === 1'b1 && bus.INST_READOUT !== 8'h00) begin
        errors++;
        $display("FAIL inst_while_pending: inst=%b required 00000000", bus.INST_READOUT);
      end
      if (bus.DATA_VALID === 1'b1 && bus.DATA_READY) begin
        vectors++;
        rx_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: data=%h required no word", bus.DATA_OUT);
        end else begin
          logic [15:0] exp;
          exp = sb.pop_front();
          if (bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL word: data=%h required %h", bus.DATA_OUT, exp);
          end
        end
      end
      pend      = (bus.DATA_VALID === 1'b1) && !bus.DATA_READY;
      pend_data = bus.DATA_OUT;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic do_start(input logic [7:0] m, input bit push);
    @(negedge clk);
    bus.CH_MASK = m;
    bus.START   = 1'b1;
    cur_mask    = m;
    if (push) begin
      for (int c = 0; c < 8; c++)
        if (m[c])
          for (int r = 0; r < 6; r++) sb.push_back({3'(c), 3'(r), val[c][r]});
    end
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int start_cyc, input int budget, output int cyc);
    cyc = start_cyc;
    while (bus.DONE !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.DONE !== 1'b1) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: DONE not seen by cycle %0d", budget);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (bus.INST_READOUT !== 8'h00 || bus.SELECT_REG !== 3'd0 || bus.DATA_OUT !== 16'h0000 ||
        bus.DATA_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL %s: inst=%b sel=%0d data=%h valid=%b busy=%b done=%b required all 0",
               tag, bus.INST_READOUT, bus.SELECT_REG, bus.DATA_OUT, bus.DATA_VALID, bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // Reset during ch2/reg3 SHIFT: word 15 loads at N181, shifting N182..N191.
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 6; r++) val[c][r] = 10'((c * 131 + r * 57 + 3) & 10'h3FF);
    do_start(8'h07, 1'b1);
    repeat (185) @(negedge clk);
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.SELECT_REG !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_pos: busy=%b sel=%0d required busy=1 sel=3", bus.BUSY, bus.SELECT_REG);
    end
    #1 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_shift");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_idle_outputs("no_resume");
  endtask

  task automatic test_single_channel;
    int cyc;
    val[0][0] = 10'h3FF; val[0][1] = 10'h001; val[0][2] = 10'h2AA;
    val[0][3] = 10'h155; val[0][4] = 10'h200; val[0][5] = 10'h005;
    rx_count = 0;
    sb.push_back(16'h03FF); sb.push_back(16'h0401); sb.push_back(16'h0AAA);
    sb.push_back(16'h0D55); sb.push_back(16'h1200); sb.push_back(16'h1405);
    do_start(8'h01, 1'b0);
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.INST_READOUT !== 8'h01 || bus.SELECT_REG !== 3'd0) begin
      errors++;
      $display("FAIL first_load: busy=%b inst=%b sel=%0d required 1 00000001 0", bus.BUSY, bus.INST_READOUT, bus.SELECT_REG);
    end
    wait_done(1, 400, cyc);
    vectors++;
    if (cyc !== 73 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_done_time: cycle=%0d busy=%b required 73 busy=0", cyc, bus.BUSY);
    end
    @(negedge clk);
    vectors++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || rx_count !== 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b words=%0d left=%0d required 0 0 6 0", bus.DONE, bus.BUSY, rx_count, sb.size());
    end
  endtask

  task automatic test_multi_channel;
    int cyc;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 6; r++) val[c][r] = 10'((c * 97 + r * 31 + 5) & 10'h3FF);
    rx_count = 0;
    do_start(8'hA4, 1'b1);
    wait_done(1, 800, cyc);
    vectors++;
    if (cyc !== 217 || rx_count !== 18 || sb.size() != 0) begin
      errors++;
      $display("FAIL multi_sweep: cycle=%0d words=%0d left=%0d required 217 18 0", cyc, rx_count, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    rx_count = 0;
    bp_mode  = 1'b1;
    do_start(8'h03, 1'b1);
    wait_done(1, 2000, cyc);
    bp_mode = 1'b0;
    vectors++;
    if (rx_count !== 12 || sb.size() != 0 || cyc < 145) begin
      errors++;
      $display("FAIL backpressure: words=%0d left=%0d cycle=%0d required 12 0 >=145", rx_count, sb.size(), cyc);
    end
  endtask

  task automatic test_mask_zero;
    rx_count = 0;
    do_start(8'h00, 1'b0);
    vectors++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b1 || bus.INST_READOUT !== 8'h00 || bus.DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL mask0_t1: done=%b busy=%b inst=%b valid=%b required 1 1 0 0", bus.DONE, bus.BUSY, bus.INST_READOUT, bus.DATA_VALID);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || rx_count !== 0) begin
      errors++;
      $display("FAIL mask0_after: done=%b busy=%b words=%0d required 0 0 0", bus.DONE, bus.BUSY, rx_count);
    end
  endtask

  task automatic test_ignore_midsweep;
    int cyc;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 6; r++) val[c][r] = 10'(($urandom() ^ (c << 3)) & 10'h3FF);
    rx_count = 0;
    do_start(8'h05, 1'b1);
    repeat (30) @(negedge clk);
    bus.START   = 1'b1;
    bus.CH_MASK = 8'hFF;
    @(negedge clk);
    bus.START   = 1'b0;
    bus.CH_MASK = 8'h0A;
    wait_done(32, 800, cyc);
    vectors++;
    if (cyc !== 145 || rx_count !== 12 || sb.size() != 0) begin
      errors++;
      $display("FAIL ignore_midsweep: cycle=%0d words=%0d left=%0d required 145 12 0", cyc, rx_count, sb.size());
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.BUSY !== 1'b0 || bus.DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL ignore_restart: busy=%b valid=%b required 0 0", bus.BUSY, bus.DATA_VALID);
    end
  endtask

  initial begin
    bus.START      = 1'b0;
    bus.CH_MASK    = 8'h00;
    bus.DATA_READY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chsr[c] = 10'd0;
      for (int r = 0; r < 6; r++) val[c][r] = 10'd0;
    end
    test_reset();
    test_single_channel();
    test_multi_channel();
    test_backpressure();
    test_mask_zero();
    test_ignore_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
